legv8_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the LEGv8 datapath (PC, IR, register file, ALU, data path to a shared instruction/data memory) around the existing instruction decoder.
- Takes opcode bits from the IR, the ALU zero flag and a memory ready handshake.
- Drives datapath enables and selects, one memory request at a time.
- Retires one instruction per pass and counts retirements.

---
 rtl/legv8_multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing,
// a memory wait watchdog and a retired-instruction counter.
//   state  | meaning
//   IDLE   | waiting for run
//   FETCH  | instruction read from PC address
//   DECODE | classify opcode, latch class
//   EXEC   | ALU op, branch resolution
//   MEM    | data read/write at ALU address
//   WB     | register file write
//   HALT   | stopped on timeout or illegal opcode, exits only by reset
module legv8_multicycle_ctrl #(
    parameter int COUNT_W     = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [10:0]        opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               reg2loc,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               link,
    output logic [1:0]         alu_op,
    output logic [2:0]         state,
    output logic               busy,
    output logic               halted,
    output logic               timeout,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_R, C_I, C_LD, C_ST, C_CBZ, C_B, C_BL, C_MOVZ
    } cls_t;

    state_t            st, st_nx;
    cls_t              cls_q, dec_cls;
    logic [WAIT_W-1:0] wait_q;
    logic              retire, halt_to, halt_ill, wait_load, wait_dec;

    // B and BL are checked first so their wide don't-care fields cannot alias other classes
    always_comb begin
        dec_cls = C_NONE;
        if (opcode[10:5] == 6'b000101)
            dec_cls = C_B;
        else if (opcode[10:5] == 6'b100101)
            dec_cls = C_BL;
        else if (opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
                 opcode == 11'b10001010000 || opcode == 11'b10101010000)
            dec_cls = C_R;
        else if (opcode[10:1] == 10'b1001000100 || opcode[10:1] == 10'b1101000100)
            dec_cls = C_I;
        else if (opcode == 11'b11111000010)
            dec_cls = C_LD;
        else if (opcode == 11'b11111000000)
            dec_cls = C_ST;
        else if (opcode[10:3] == 8'b10110100)
            dec_cls = C_CBZ;
        else if (opcode[10:2] == 9'b110100101)
            dec_cls = C_MOVZ;
    end

    always_comb begin
        st_nx      = st;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        link       = 1'b0;
        alu_op     = 2'b00;
        halted     = 1'b0;
        retire     = 1'b0;
        halt_to    = 1'b0;
        halt_ill   = 1'b0;
        wait_dec   = 1'b0;
        case (st)
            S_IDLE: if (run) st_nx = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    st_nx    = S_DECODE;
                end else if (wait_q == '0) begin
                    halt_to = 1'b1;
                    st_nx   = S_HALT;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            S_DECODE: begin
                reg2loc = (dec_cls == C_ST) || (dec_cls == C_CBZ);
                if (dec_cls == C_NONE) begin
                    halt_ill = 1'b1;
                    st_nx    = S_HALT;
                end else begin
                    st_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                reg2loc = (cls_q == C_ST) || (cls_q == C_CBZ);
                case (cls_q)
                    C_R:  begin alu_op = 2'b10; st_nx = S_WB; end
                    C_I:  begin alu_op = 2'b10; alu_src = 1'b1; st_nx = S_WB; end
                    C_LD, C_ST: begin alu_src = 1'b1; st_nx = S_MEM; end
                    C_CBZ: begin
                        alu_op   = 2'b01;
                        pc_write = zero;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    C_B:  begin pc_write = 1'b1; pc_src = 1'b1; retire = 1'b1; end
                    C_BL: begin pc_write = 1'b1; pc_src = 1'b1; st_nx = S_WB; end
                    C_MOVZ: begin alu_op = 2'b11; alu_src = 1'b1; st_nx = S_WB; end
                    default: st_nx = S_IDLE;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_q == C_ST);
                reg2loc  = (cls_q == C_ST);
                if (mem_ready) begin
                    if (cls_q == C_LD) st_nx = S_WB;
                    else               retire = 1'b1;
                end else if (wait_q == '0) begin
                    halt_to = 1'b1;
                    st_nx   = S_HALT;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LD);
                link       = (cls_q == C_BL);
                retire     = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: st_nx = S_IDLE;
        endcase
        if (retire) st_nx = run ? S_FETCH : S_IDLE;
        // watchdog counts down from MEM_TIMEOUT-1; terminal count with no ready halts
        wait_load = (st_nx != st) && (st_nx == S_FETCH || st_nx == S_MEM);
        busy      = (st != S_IDLE) && (st != S_HALT);
        state     = st;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= S_IDLE;
            cls_q   <= C_NONE;
            wait_q  <= '0;
            retired <= '0;
            timeout <= 1'b0;
            illegal <= 1'b0;
        end else begin
            st <= st_nx;
            if (st == S_DECODE) cls_q <= dec_cls;
            if (wait_load)     wait_q <= WAIT_LOAD;
            else if (wait_dec) wait_q <= wait_q - WAIT_W'(1);
            if (retire)   retired <= retired + COUNT_W'(1);
            if (halt_to)  timeout <= 1'b1;
            if (halt_ill) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl: per-cycle state/control tables per instruction class,
// watchdog timeout, illegal opcode, reset during MEM and counter wrap.
module tb_legv8_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
    logic        reg2loc, alu_src, mem_to_reg, reg_write, link;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        busy, halted, timeout, illegal;
    logic [1:0]  retired;
    logic [12:0] ctl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    legv8_multicycle_ctrl #(.COUNT_W(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .link(link),
        .alu_op(alu_op), .state(state), .busy(busy), .halted(halted), .timeout(timeout),
        .illegal(illegal), .retired(retired)
    );

    assign ctl = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg2loc,
                  alu_src, mem_to_reg, reg_write, link, alu_op};

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXEC = 3'd3,
                           ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

    localparam logic [12:0] B_REQ = 13'h1000, B_WE = 13'h0800, B_ASEL = 13'h0400,
                            B_IRW = 13'h0200, B_PCW = 13'h0100, B_PCSRC = 13'h0080,
                            B_R2L = 13'h0040, B_ASRC = 13'h0020, B_M2R = 13'h0010,
                            B_RW = 13'h0008, B_LINK = 13'h0004;

    localparam logic [12:0] C_0      = 13'h0000;
    localparam logic [12:0] C_FETCH  = B_REQ;
    localparam logic [12:0] C_FR     = B_REQ | B_IRW | B_PCW;
    localparam logic [12:0] C_R2L    = B_R2L;
    localparam logic [12:0] C_EX_I   = B_ASRC | 13'd2;
    localparam logic [12:0] C_WB     = B_RW;
    localparam logic [12:0] C_CBZ1   = B_PCW | B_PCSRC | B_R2L | 13'd1;
    localparam logic [12:0] C_CBZ0   = B_PCSRC | B_R2L | 13'd1;
    localparam logic [12:0] C_EX_LD  = B_ASRC;
    localparam logic [12:0] C_MEM_LD = B_REQ | B_ASEL;
    localparam logic [12:0] C_WB_LD  = B_M2R | B_RW;
    localparam logic [12:0] C_EX_ST  = B_R2L | B_ASRC;
    localparam logic [12:0] C_MEM_ST = B_REQ | B_WE | B_ASEL | B_R2L;
    localparam logic [12:0] C_EX_BR  = B_PCW | B_PCSRC;
    localparam logic [12:0] C_WB_BL  = B_RW | B_LINK;

    localparam logic [31:0] I_ADDI = 32'h910203E0, I_CBZ = 32'hB42D3945,
                            I_LDUR = 32'hF8462060, I_STUR = 32'hF8048044,
                            I_BL   = 32'h94101001, I_B    = 32'h14000003,
                            I_ZERO = 32'h00000000;

    typedef struct packed {
        logic        run;
        logic        zero;
        logic        rdy;
        logic [2:0]  st;
        logic [12:0] ctl;
    } step_t;

    function automatic step_t stp(input logic r, input logic z, input logic m,
                                  input logic [2:0] s, input logic [12:0] c);
        step_t t;
        t.run = r; t.zero = z; t.rdy = m; t.st = s; t.ctl = c;
        return t;
    endfunction

    task automatic set_instr(input logic [31:0] w);
        opcode = w[31:21];
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; mem_ready = 1'b1; zero = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; #1;
        n_tests++;
        if ({state, ctl} !== {ST_IDLE, C_0}) begin
            n_fail++; $display("FAIL reset_ctl state=%0d ctl=%h want state=0 ctl=0", state, ctl);
        end
        n_tests++;
        if ({busy, halted, timeout, illegal, retired} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags busy=%b halted=%b timeout=%b illegal=%b retired=%0d want all 0",
                     busy, halted, timeout, illegal, retired);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (state !== ST_IDLE) begin
            n_fail++; $display("FAIL idle_hold state=%0d want 0", state);
        end
    endtask

    task automatic test_addi();
        step_t seq[$];
        do_reset(); set_instr(I_ADDI);
        seq.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        seq.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq.push_back(stp(1, 0, 0, ST_DEC, C_0));
        seq.push_back(stp(1, 0, 0, ST_EXEC, C_EX_I));
        seq.push_back(stp(1, 0, 0, ST_WB, C_WB));
        seq.push_back(stp(1, 0, 0, ST_FETCH, C_FETCH));
        foreach (seq[i]) begin
            run = seq[i].run; zero = seq[i].zero; mem_ready = seq[i].rdy; #1;
            n_tests++;
            if (state !== seq[i].st || ctl !== seq[i].ctl) begin
                n_fail++;
                $display("FAIL addi cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (retired !== 2'd1) begin
            n_fail++; $display("FAIL addi_retired got %0d want 1", retired);
        end
    endtask

    task automatic test_cbz();
        step_t seq[$];
        do_reset(); set_instr(I_CBZ);
        seq.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        seq.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq.push_back(stp(1, 0, 0, ST_DEC, C_R2L));
        seq.push_back(stp(1, 1, 0, ST_EXEC, C_CBZ1));
        seq.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq.push_back(stp(1, 0, 0, ST_DEC, C_R2L));
        seq.push_back(stp(1, 0, 0, ST_EXEC, C_CBZ0));
        seq.push_back(stp(1, 0, 0, ST_FETCH, C_FETCH));
        foreach (seq[i]) begin
            run = seq[i].run; zero = seq[i].zero; mem_ready = seq[i].rdy; #1;
            n_tests++;
            if (state !== seq[i].st || ctl !== seq[i].ctl) begin
                n_fail++;
                $display("FAIL cbz cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (retired !== 2'd2) begin
            n_fail++; $display("FAIL cbz_retired got %0d want 2", retired);
        end
    endtask

    task automatic test_ldur();
        step_t seq[$];
        do_reset(); set_instr(I_LDUR);
        seq.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        seq.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq.push_back(stp(1, 0, 0, ST_DEC, C_0));
        seq.push_back(stp(1, 0, 0, ST_EXEC, C_EX_LD));
        seq.push_back(stp(1, 0, 0, ST_MEM, C_MEM_LD));
        seq.push_back(stp(1, 0, 0, ST_MEM, C_MEM_LD));
        seq.push_back(stp(1, 0, 0, ST_MEM, C_MEM_LD));
        seq.push_back(stp(1, 0, 1, ST_MEM, C_MEM_LD));
        seq.push_back(stp(1, 0, 0, ST_WB, C_WB_LD));
        seq.push_back(stp(1, 0, 0, ST_FETCH, C_FETCH));
        foreach (seq[i]) begin
            run = seq[i].run; zero = seq[i].zero; mem_ready = seq[i].rdy; #1;
            n_tests++;
            if (state !== seq[i].st || ctl !== seq[i].ctl) begin
                n_fail++;
                $display("FAIL ldur cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if ({retired, timeout} !== {2'd1, 1'b0}) begin
            n_fail++; $display("FAIL ldur_done retired=%0d timeout=%b want 1/0", retired, timeout);
        end
    endtask

    task automatic test_stur();
        step_t seq[$];
        do_reset(); set_instr(I_STUR);
        seq.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        seq.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq.push_back(stp(1, 0, 0, ST_DEC, C_R2L));
        seq.push_back(stp(1, 0, 0, ST_EXEC, C_EX_ST));
        seq.push_back(stp(1, 0, 1, ST_MEM, C_MEM_ST));
        seq.push_back(stp(1, 0, 0, ST_FETCH, C_FETCH));
        foreach (seq[i]) begin
            run = seq[i].run; zero = seq[i].zero; mem_ready = seq[i].rdy; #1;
            n_tests++;
            if (state !== seq[i].st || ctl !== seq[i].ctl) begin
                n_fail++;
                $display("FAIL stur cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (retired !== 2'd1) begin
            n_fail++; $display("FAIL stur_retired got %0d want 1", retired);
        end
    endtask

    task automatic test_bl();
        step_t seq[$];
        do_reset(); set_instr(I_BL);
        seq.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        seq.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq.push_back(stp(1, 0, 0, ST_DEC, C_0));
        seq.push_back(stp(1, 0, 0, ST_EXEC, C_EX_BR));
        seq.push_back(stp(1, 0, 0, ST_WB, C_WB_BL));
        seq.push_back(stp(1, 0, 0, ST_FETCH, C_FETCH));
        foreach (seq[i]) begin
            run = seq[i].run; zero = seq[i].zero; mem_ready = seq[i].rdy; #1;
            n_tests++;
            if (state !== seq[i].st || ctl !== seq[i].ctl) begin
                n_fail++;
                $display("FAIL bl cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (retired !== 2'd1) begin
            n_fail++; $display("FAIL bl_retired got %0d want 1", retired);
        end
    endtask

    task automatic test_illegal();
        step_t seq[$];
        do_reset(); set_instr(I_ZERO);
        seq.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        seq.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq.push_back(stp(1, 0, 0, ST_DEC, C_0));
        seq.push_back(stp(1, 0, 1, ST_HALT, C_0));
        seq.push_back(stp(1, 0, 1, ST_HALT, C_0));
        seq.push_back(stp(1, 0, 1, ST_HALT, C_0));
        foreach (seq[i]) begin
            run = seq[i].run; zero = seq[i].zero; mem_ready = seq[i].rdy; #1;
            n_tests++;
            if (state !== seq[i].st || ctl !== seq[i].ctl) begin
                n_fail++;
                $display("FAIL illegal cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if ({halted, illegal, timeout, busy, retired} !== 6'b1100_00) begin
            n_fail++;
            $display("FAIL illegal_flags halted=%b illegal=%b timeout=%b busy=%b retired=%0d want 1/1/0/0/0",
                     halted, illegal, timeout, busy, retired);
        end
        do_reset(); #1;
        n_tests++;
        if ({state, halted, illegal} !== {ST_IDLE, 2'b00}) begin
            n_fail++;
            $display("FAIL illegal_clear state=%0d halted=%b illegal=%b want 0/0/0", state, halted, illegal);
        end
    endtask

    task automatic test_timeout();
        step_t seq[$];
        step_t seq2[$];
        do_reset(); set_instr(I_ADDI);
        seq.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        for (int k = 0; k < 4; k++) seq.push_back(stp(1, 0, 0, ST_FETCH, C_FETCH));
        seq.push_back(stp(1, 0, 0, ST_HALT, C_0));
        foreach (seq[i]) begin
            run = seq[i].run; zero = seq[i].zero; mem_ready = seq[i].rdy; #1;
            n_tests++;
            if (state !== seq[i].st || ctl !== seq[i].ctl) begin
                n_fail++;
                $display("FAIL timeout cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if ({halted, timeout, illegal} !== 3'b110) begin
            n_fail++;
            $display("FAIL timeout_flags halted=%b timeout=%b illegal=%b want 1/1/0", halted, timeout, illegal);
        end
        do_reset();
        seq2.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        for (int k = 0; k < 3; k++) seq2.push_back(stp(1, 0, 0, ST_FETCH, C_FETCH));
        seq2.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq2.push_back(stp(1, 0, 0, ST_DEC, C_0));
        seq2.push_back(stp(1, 0, 0, ST_EXEC, C_EX_I));
        foreach (seq2[i]) begin
            run = seq2[i].run; zero = seq2[i].zero; mem_ready = seq2[i].rdy; #1;
            n_tests++;
            if (state !== seq2[i].st || ctl !== seq2[i].ctl) begin
                n_fail++;
                $display("FAIL late_ready cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq2[i].st, seq2[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if ({timeout, halted} !== 2'b00) begin
            n_fail++; $display("FAIL late_ready_flags timeout=%b halted=%b want 0/0", timeout, halted);
        end
    endtask

    task automatic test_reset_mid_mem();
        step_t seq[$];
        step_t seq2[$];
        do_reset(); set_instr(I_STUR);
        seq.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        seq.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq.push_back(stp(1, 0, 0, ST_DEC, C_R2L));
        seq.push_back(stp(1, 0, 0, ST_EXEC, C_EX_ST));
        seq.push_back(stp(1, 0, 1, ST_MEM, C_MEM_ST));
        foreach (seq[i]) begin
            run = seq[i].run; zero = seq[i].zero; mem_ready = seq[i].rdy; #1;
            n_tests++;
            if (state !== seq[i].st || ctl !== seq[i].ctl) begin
                n_fail++;
                $display("FAIL b2b_st cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        set_instr(I_LDUR);
        seq2.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
        seq2.push_back(stp(1, 0, 0, ST_DEC, C_0));
        seq2.push_back(stp(1, 0, 0, ST_EXEC, C_EX_LD));
        seq2.push_back(stp(1, 0, 0, ST_MEM, C_MEM_LD));
        foreach (seq2[i]) begin
            run = seq2[i].run; zero = seq2[i].zero; mem_ready = seq2[i].rdy; #1;
            n_tests++;
            if (state !== seq2[i].st || ctl !== seq2[i].ctl) begin
                n_fail++;
                $display("FAIL b2b_ld cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq2[i].st, seq2[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if ({state, mem_req, retired} !== {ST_MEM, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL pre_reset state=%0d mem_req=%b retired=%0d want 4/1/1", state, mem_req, retired);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; #1;
        n_tests++;
        if ({state, mem_req, retired} !== {ST_IDLE, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL mid_mem_reset state=%0d mem_req=%b retired=%0d want 0/0/0", state, mem_req, retired);
        end
    endtask

    task automatic test_wrap();
        step_t seq[$];
        do_reset(); set_instr(I_B);
        seq.push_back(stp(1, 0, 0, ST_IDLE, C_0));
        for (int k = 0; k < 5; k++) begin
            seq.push_back(stp(1, 0, 1, ST_FETCH, C_FR));
            seq.push_back(stp(1, 0, 0, ST_DEC, C_0));
            seq.push_back(stp((k < 4) ? 1'b1 : 1'b0, 0, 0, ST_EXEC, C_EX_BR));
        end
        seq.push_back(stp(0, 0, 1, ST_IDLE, C_0));
        seq.push_back(stp(0, 0, 1, ST_IDLE, C_0));
        foreach (seq[i]) begin
            run = seq[i].run; zero = seq[i].zero; mem_ready = seq[i].rdy; #1;
            n_tests++;
            if (state !== seq[i].st || ctl !== seq[i].ctl) begin
                n_fail++;
                $display("FAIL wrap cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                         i, state, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if ({state, busy, retired} !== {ST_IDLE, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL wrap_count state=%0d busy=%b retired=%0d want 0/0/1", state, busy, retired);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_cbz();
        test_ldur();
        test_stur();
        test_bl();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
